// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory response unit.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] MEM_OP_WR = 2'b11;
  localparam logic [1:0] MEM_OP_RD = 2'b10;

endpackage

// File: rtl/mem_resp_array.sv
// Word storage: 2^AddrW x 16 bits, synchronous write, combinational read.
// Contents have no reset.
module mem_resp_array #(
  parameter int unsigned AddrW = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [15:0]      wdata_i,
  output logic [15:0]      rdata_o
);

  logic [15:0] mem_q [2**AddrW];

  // Write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_resp_unit.sv
// Fixed-latency memory response unit: accepts one read/write request, stalls the requester
// for LATENCY cycles, then pulses done. Writes commit and reads capture data on the
// DONE-entry edge only.
// Optional build macro MEM_ALIGN_CHECK_EN: reject requests with addr[0]=1 (done + err,
// no side effects).
module mem_resp_unit
  import mem_resp_pkg::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mem_op,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        done,
  output logic        stall,
  output logic        err
);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               accept;
  logic               commit;
  logic               rejected;
  logic               mem_we;
  logic [ADDR_W-1:0]  word_q;
  logic [15:0]        wdata_q;
  logic               is_wr_q;
  logic [15:0]        rdata;
  logic [15:0]        data_out_q;
  logic               unused_addr;

  // A new request can start from IDLE or straight out of DONE.
  assign accept = !rst && mem_op[1] && ((state_q == IDLE) || (state_q == DONE));
  // True in the last BUSY cycle, so the following edge is the DONE-entry edge.
  assign commit = !rst && (state_q == BUSY) && (cnt_q == 4'd0);

  assign unused_addr = ^addr;

`ifdef MEM_ALIGN_CHECK_EN
  logic misaligned_q;

  // Remember whether the accepted request was misaligned
  always_ff @(posedge clk) begin
    if (accept) begin
      misaligned_q <= addr[0];
    end
  end

  assign rejected = misaligned_q;
`else
  assign rejected = 1'b0;
`endif

  // State register and latency counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = 4'(LATENCY - 1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    done  = (state_q == DONE);
    stall = (state_q == BUSY) || accept;
    err   = (state_q == DONE) && rejected;
  end

  // Latch the request so later input changes are ignored
  always_ff @(posedge clk) begin
    if (accept) begin
      word_q  <= addr[ADDR_W:1];
      wdata_q <= data_in;
      is_wr_q <= (mem_op == MEM_OP_WR);
    end
  end

  assign mem_we = commit && is_wr_q && !rejected;

  // Read data captured on completion of an accepted read
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= 16'h0000;
    end else if (commit && !is_wr_q && !rejected) begin
      data_out_q <= rdata;
    end
  end

  assign data_out = data_out_q;

  mem_resp_array #(
    .AddrW (ADDR_W)
  ) u_array (
    .clk_i   (clk),
    .we_i    (mem_we),
    .addr_i  (word_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_mem_resp_unit.sv
// Randomized self-checking bench for mem_resp_unit against a word-array reference model.
module tb_mem_resp_unit;

  localparam int unsigned LAT = 4;
  localparam int unsigned AW  = 8;
  localparam logic [1:0]  WR  = 2'b11;
  localparam logic [1:0]  RD  = 2'b10;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  mem_op;
  logic [15:0] addr, data_in, data_out;
  logic        done, stall, err;

  logic        rst1;
  logic [1:0]  mem_op1;
  logic [15:0] addr1, data_in1, data_out1;
  logic        done1, stall1, err1;

  mem_resp_unit #(.LATENCY(LAT), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .mem_op(mem_op), .addr(addr), .data_in(data_in),
    .data_out(data_out), .done(done), .stall(stall), .err(err)
  );

  mem_resp_unit #(.LATENCY(1), .ADDR_W(8)) dut1 (
    .clk(clk), .rst(rst1), .mem_op(mem_op1), .addr(addr1), .data_in(data_in1),
    .data_out(data_out1), .done(done1), .stall(stall1), .err(err1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [15:0] ref_mem [256];
  logic [15:0] ref_dout;
  logic        ref_err;

  // Observations from the last request
  int   obs_lat;
  logic obs_err;
  logic obs_busy_ok;

  function automatic int widx(input logic [15:0] a);
    return (int'(a) / 2) % (1 << AW);
  endfunction

  task automatic model_req(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d);
    ref_err = 1'b0;
    if (op[1]) begin
      if (ALIGN && a[0]) ref_err = 1'b1;
      else if (op[0]) ref_mem[widx(a)] = d;
      else ref_dout = ref_mem[widx(a)];
    end
  endtask

  // Present a request at a negedge and hold it until done or timeout.
  task automatic drive_req(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d);
    mem_op  = op;
    addr    = a;
    data_in = d;
    #1;
    obs_busy_ok = (stall === 1'b1);
    obs_lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        obs_lat = k;
        break;
      end
      if (stall !== 1'b1 || err !== 1'b0) obs_busy_ok = 1'b0;
    end
    obs_err = err;
  endtask

  task automatic release_req();
    mem_op = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_op = 2'b00;
    addr = 16'h0;
    data_in = 16'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ref_dout = 16'h0000;
    checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL reset_data_out got %h want 0000", data_out); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
  endtask

  task automatic test_fill();
    logic ok = 1'b1;
    logic [15:0] d;
    for (int i = 0; i < 256; i++) begin
      d = 16'($urandom);
      model_req(WR, 16'(i * 2), d);
      drive_req(WR, 16'(i * 2), d);
      if (obs_lat != LAT + 1) ok = 1'b0;
      release_req();
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL fill_latency got bad latency want %0d", LAT + 1); end
  endtask

  task automatic test_write_read();
    model_req(WR, 16'h0010, 16'hBEEF);
    drive_req(WR, 16'h0010, 16'hBEEF);
    checks++; if (obs_lat != 5) begin errors++; $display("FAIL wr_latency got %0d want 5", obs_lat); end
    checks++; if (obs_busy_ok !== 1'b1) begin errors++; $display("FAIL wr_stall got low want high"); end
    release_req();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width got %b want 0", done); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL idle_stall got %b want 0", stall); end
    model_req(RD, 16'h0010, 16'h0);
    drive_req(RD, 16'h0010, 16'h0);
    checks++; if (obs_lat != 5) begin errors++; $display("FAIL rd_latency got %0d want 5", obs_lat); end
    checks++; if (data_out !== 16'hBEEF) begin errors++; $display("FAIL rd_beef got %h want beef", data_out); end
    release_req();
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, d;
    a = 16'($urandom_range(0, 255) * 2);
    d = 16'($urandom);
    model_req(WR, a, d);
    drive_req(WR, a, d);
    checks++; if (obs_lat != LAT + 1) begin errors++; $display("FAIL b2b_wr_latency got %0d want %0d", obs_lat, LAT + 1); end
    model_req(RD, a, 16'h0);
    drive_req(RD, a, 16'h0);
    checks++; if (obs_busy_ok !== 1'b1) begin errors++; $display("FAIL b2b_stall got dropped want held"); end
    checks++; if (obs_lat != LAT + 1) begin errors++; $display("FAIL b2b_rd_latency got %0d want %0d", obs_lat, LAT + 1); end
    checks++; if (data_out !== d) begin errors++; $display("FAIL b2b_data got %h want %h", data_out, d); end
    release_req();
  endtask

  task automatic test_busy_ignore();
    logic [15:0] prior_b;
    int lat;
    prior_b = ref_mem[widx(16'h0040)];
    model_req(RD, 16'h0020, 16'h0);
    mem_op = RD;
    addr = 16'h0020;
    data_in = 16'h0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (k == 2) begin
        mem_op = WR;
        addr = 16'h0040;
        data_in = 16'h1234;
      end
      if (k == 3) mem_op = 2'b00;
    end
    checks++; if (lat != LAT + 1) begin errors++; $display("FAIL busy_latency got %0d want %0d", lat, LAT + 1); end
    checks++; if (data_out !== ref_dout) begin errors++; $display("FAIL busy_rd_data got %h want %h", data_out, ref_dout); end
    release_req();
    model_req(RD, 16'h0040, 16'h0);
    drive_req(RD, 16'h0040, 16'h0);
    checks++; if (data_out !== prior_b) begin errors++; $display("FAIL busy_ignored got %h want %h", data_out, prior_b); end
    release_req();
  endtask

  task automatic test_reset_abort();
    logic [15:0] prior;
    logic seen;
    prior = ref_mem[widx(16'h0004)];
    mem_op = WR;
    addr = 16'h0004;
    data_in = 16'hAAAA;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    mem_op = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    ref_dout = 16'h0000;
    seen = done;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_done got pulse want none"); end
    checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL abort_dout got %h want 0000", data_out); end
    model_req(RD, 16'h0004, 16'h0);
    drive_req(RD, 16'h0004, 16'h0);
    checks++; if (data_out !== prior) begin errors++; $display("FAIL abort_nowrite got %h want %h", data_out, prior); end
    release_req();
  endtask

  task automatic test_align();
    logic [15:0] prior, d, want;
    prior = ref_mem[1];
    d = 16'($urandom);
    model_req(WR, 16'h0003, d);
    drive_req(WR, 16'h0003, d);
    checks++; if (obs_lat != LAT + 1) begin errors++; $display("FAIL align_latency got %0d want %0d", obs_lat, LAT + 1); end
    checks++; if (obs_err !== ALIGN) begin errors++; $display("FAIL align_err got %b want %b", obs_err, ALIGN); end
    release_req();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL align_err_width got %b want 0", err); end
    want = ALIGN ? prior : d;
    model_req(RD, 16'h0002, 16'h0);
    drive_req(RD, 16'h0002, 16'h0);
    checks++; if (data_out !== want) begin errors++; $display("FAIL align_word1 got %h want %h", data_out, want); end
    release_req();
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [15:0] a, d;
    int r;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 3);
      a = 16'($urandom);
      d = 16'($urandom);
      if (r == 0) begin
        mem_op = 2'($urandom_range(0, 1));
        addr = a;
        data_in = d;
        @(negedge clk);
        checks++; if (done !== 1'b0 || data_out !== ref_dout) begin
          errors++; $display("FAIL rnd_noop got done=%b dout=%h want done=0 dout=%h", done, data_out, ref_dout);
        end
        mem_op = 2'b00;
      end else begin
        op = (r == 1) ? RD : WR;
        model_req(op, a, d);
        drive_req(op, a, d);
        checks++; if (obs_lat != LAT + 1) begin errors++; $display("FAIL rnd_latency got %0d want %0d", obs_lat, LAT + 1); end
        checks++; if (obs_err !== ref_err) begin errors++; $display("FAIL rnd_err got %b want %b", obs_err, ref_err); end
        checks++; if (data_out !== ref_dout) begin errors++; $display("FAIL rnd_dout got %h want %h", data_out, ref_dout); end
        checks++; if (obs_busy_ok !== 1'b1) begin errors++; $display("FAIL rnd_busy got bad stall/err want stall=1 err=0"); end
        release_req();
      end
    end
  endtask

  task automatic test_latency_one();
    int lat;
    rst1 = 1'b1;
    mem_op1 = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    checks++; if (data_out1 !== 16'h0000) begin errors++; $display("FAIL l1_reset got %h want 0000", data_out1); end
    // 0x03FE and 0x01FE both map to word 255 with an 8-bit word address
    mem_op1 = WR; addr1 = 16'h03FE; data_in1 = 16'h5A5A;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done1 === 1'b1) begin lat = k; break; end
    end
    checks++; if (lat != 2) begin errors++; $display("FAIL l1_wr_latency got %0d want 2", lat); end
    mem_op1 = 2'b00;
    @(negedge clk);
    mem_op1 = RD; addr1 = 16'h01FE; data_in1 = 16'h0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done1 === 1'b1) begin lat = k; break; end
    end
    checks++; if (lat != 2) begin errors++; $display("FAIL l1_rd_latency got %0d want 2", lat); end
    checks++; if (data_out1 !== 16'h5A5A || err1 !== 1'b0) begin
      errors++; $display("FAIL l1_wrap got %h err=%b want 5a5a err=0", data_out1, err1);
    end
    mem_op1 = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    mem_op = 2'b00;
    addr = 16'h0;
    data_in = 16'h0;
    rst1 = 1'b1;
    mem_op1 = 2'b00;
    addr1 = 16'h0;
    data_in1 = 16'h0;
    ref_dout = 16'h0;
    ref_err = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_write_read();
    test_back_to_back();
    test_busy_ignore();
    test_reset_abort();
    test_align();
    test_random();
    test_latency_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
